// File: rtl/mem_arbiter_pkg.sv
// Shared widths, constants and FSM encoding for the instruction/data memory bus arbiter.
package mem_arbiter_pkg;

    localparam int unsigned InstAddrBus = 32;
    localparam int unsigned InstBus     = 32;
    localparam int unsigned CntW        = 8;

    localparam logic              RstEnable = 1'b1;
    localparam logic [31:0]       ZeroWord  = 32'h0000_0000;
    localparam logic [3:0]        FetchSel  = 4'b1111;

    typedef enum logic [1:0] {
        StIdle,
        StIfBusy,
        StDmBusy,
        StResp
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Serialises instruction fetch and MEM-stage data accesses onto one memory bus,
// data first, with a bounded wait-state timeout and a pipeline stall request.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_req,
    input  logic [InstAddrBus-1:0] if_addr,
    output logic                   if_ack,
    output logic [InstBus-1:0]     if_rdata,
    output logic                   if_err,
    input  logic                   dm_req,
    input  logic                   dm_we,
    input  logic [3:0]             dm_sel,
    input  logic [31:0]            dm_addr,
    input  logic [31:0]            dm_wdata,
    output logic                   dm_ack,
    output logic [31:0]            dm_rdata,
    output logic                   dm_err,
    output logic                   bus_req,
    output logic                   bus_we,
    output logic [3:0]             bus_sel,
    output logic [31:0]            bus_addr,
    output logic [31:0]            bus_wdata,
    input  logic                   bus_ack,
    input  logic [31:0]            bus_rdata,
    output logic                   stall_req
);

    localparam logic [CntW-1:0] CntLast = CntW'(WAIT_MAX - 1);

    arb_state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;

    logic               if_ack_q, if_ack_d;
    logic [InstBus-1:0] if_rdata_q, if_rdata_d;
    logic               if_err_q, if_err_d;
    logic               dm_ack_q, dm_ack_d;
    logic [31:0]        dm_rdata_q, dm_rdata_d;
    logic               dm_err_q, dm_err_d;

    logic timed_out;
    assign timed_out = (cnt_q == CntLast);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_sel_d   = bus_sel_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_ack_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        if_err_d    = if_err_q;
        dm_ack_d    = 1'b0;
        dm_rdata_d  = dm_rdata_q;
        dm_err_d    = dm_err_q;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (dm_req) begin
                    state_d     = StDmBusy;
                    bus_req_d   = 1'b1;
                    bus_we_d    = dm_we;
                    bus_sel_d   = dm_sel;
                    bus_addr_d  = dm_addr;
                    bus_wdata_d = dm_wdata;
                end else if (if_req) begin
                    state_d     = StIfBusy;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_sel_d   = FetchSel;
                    bus_addr_d  = if_addr;
                    bus_wdata_d = ZeroWord;
                end
            end

            StIfBusy: begin
                // A late ack on the final allowed cycle still completes cleanly.
                if (bus_ack) begin
                    state_d    = StResp;
                    bus_req_d  = 1'b0;
                    if_ack_d   = 1'b1;
                    if_rdata_d = bus_rdata;
                    if_err_d   = 1'b0;
                end else if (timed_out) begin
                    state_d    = StResp;
                    bus_req_d  = 1'b0;
                    if_ack_d   = 1'b1;
                    if_rdata_d = ZeroWord;
                    if_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StDmBusy: begin
                if (bus_ack) begin
                    state_d    = StResp;
                    bus_req_d  = 1'b0;
                    dm_ack_d   = 1'b1;
                    dm_rdata_d = bus_we_q ? ZeroWord : bus_rdata;
                    dm_err_d   = 1'b0;
                end else if (timed_out) begin
                    state_d    = StResp;
                    bus_req_d  = 1'b0;
                    dm_ack_d   = 1'b1;
                    dm_rdata_d = ZeroWord;
                    dm_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StResp: begin
                state_d = StIdle;
            end

            default: begin
                state_d   = StIdle;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= 4'b0000;
            bus_addr_q  <= ZeroWord;
            bus_wdata_q <= ZeroWord;
            if_ack_q    <= 1'b0;
            if_rdata_q  <= ZeroWord;
            if_err_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            dm_rdata_q  <= ZeroWord;
            dm_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_sel_q   <= bus_sel_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_ack_q    <= if_ack_d;
            if_rdata_q  <= if_rdata_d;
            if_err_q    <= if_err_d;
            dm_ack_q    <= dm_ack_d;
            dm_rdata_q  <= dm_rdata_d;
            dm_err_q    <= dm_err_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_sel   = bus_sel_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign if_ack    = if_ack_q;
    assign if_rdata  = if_rdata_q;
    assign if_err    = if_err_q;
    assign dm_ack    = dm_ack_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_err    = dm_err_q;

    // Registered acks let a requester release the stall in its own RESP cycle.
    assign stall_req = (if_req & ~if_ack_q) | (dm_req & ~dm_ack_q);

endmodule
